// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU constants and scoreboard types: register-file geometry,
// per-register event bundle and its signed net-delta encoding.
package reg_scoreboard_pkg;

  localparam int NREGS      = 32;
  localparam int CNT_W      = 2;
  localparam int REG_IDX_W  = 5;
  localparam int REG_SLOTS  = 1 << REG_IDX_W;
  localparam int INFLIGHT_W = 6;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // -2 .. +1 per cycle per register
  typedef logic signed [2:0] delta_t;

  typedef struct packed {
    logic inc;
    logic wb;
    logic kill;
  } reg_evt_t;

  function automatic delta_t net_delta(input reg_evt_t e);
    delta_t d;
    d = 3'sd0;
    if (e.inc)  d = d + 3'sd1;
    if (e.wb)   d = d - 3'sd1;
    if (e.kill) d = d - 3'sd1;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / write-back / kill bus between the issue stage (master) and the
// register scoreboard (slave).
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                  issue_valid;
  logic                  issue_we;
  reg_idx_t              issue_rd;
  reg_idx_t              rs1;
  reg_idx_t              rs2;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  wb_valid;
  reg_idx_t              wb_rd;
  logic                  kill_valid;
  reg_idx_t              kill_rd;
  logic                  stall;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  err;

  modport master (
    output issue_valid, issue_we, issue_rd, rs1, rs2, rs1_used, rs2_used,
    output wb_valid, wb_rd, kill_valid, kill_rd,
    input  stall, rs1_busy, rs2_busy, inflight, err
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, rs1, rs2, rs1_used, rs2_used,
    input  wb_valid, wb_rd, kill_valid, kill_rd,
    output stall, rs1_busy, rs2_busy, inflight, err
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register in-flight write counter: applies a signed net delta each
// cycle, clamps at 0 / max, and flags any attempted underflow.
module sb_counter
  import reg_scoreboard_pkg::delta_t;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  delta_t           delta_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             nz_o,
  output logic             full_o,
  output logic             uf_o
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum   = $signed({2'b00, cnt_q}) + SUM_W'(delta_i);
    uf_o  = 1'b0;
    cnt_d = sum[CNT_W-1:0];
    if (sum < 0) begin
      cnt_d = '0;
      uf_o  = 1'b1;
    end else if (sum > $signed({2'b00, CNT_MAX})) begin
      // unreachable while the issue stall honours full_o
      cnt_d = CNT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_d_o = cnt_d;
  assign nz_o    = |cnt_q;
  assign full_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gate issue on
// RAW hazards and counter saturation; tracks total in-flight writes.
module reg_scoreboard
  import reg_scoreboard_pkg::REG_IDX_W,
         reg_scoreboard_pkg::REG_SLOTS,
         reg_scoreboard_pkg::INFLIGHT_W,
         reg_scoreboard_pkg::delta_t,
         reg_scoreboard_pkg::reg_evt_t,
         reg_scoreboard_pkg::net_delta;
#(
  parameter int NREGS = reg_scoreboard_pkg::NREGS,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  logic [NREGS-1:0][CNT_W-1:0] cnt_d;
  logic [NREGS-1:0]            nz_v, full_v, uf_v;
  logic [REG_SLOTS-1:0]        nz, full;

  logic                  rs1_busy, rs2_busy, stall, inc_en;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic                  err_q, err_d;

  // widen to the full index space so any 5-bit index is in range
  assign nz   = REG_SLOTS'(nz_v);
  assign full = REG_SLOTS'(full_v);

  // counters are looked up pre-update: a write-back this cycle does not
  // clear busy until the next cycle
  assign rs1_busy = sb.rs1_used && (sb.rs1 != '0) && nz[sb.rs1];
  assign rs2_busy = sb.rs2_used && (sb.rs2 != '0) && nz[sb.rs2];
  assign stall    = sb.issue_valid &&
                    (rs1_busy || rs2_busy ||
                     (sb.issue_we && (sb.issue_rd != '0) && full[sb.issue_rd]));
  assign inc_en   = sb.issue_valid && !stall && sb.issue_we && (sb.issue_rd != '0);

  assign cnt_d[0]  = '0;
  assign nz_v[0]   = 1'b0;
  assign full_v[0] = 1'b0;
  assign uf_v[0]   = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    reg_evt_t evt;
    delta_t   delta;

    assign evt.inc  = inc_en        && (sb.issue_rd == REG_IDX_W'(i));
    assign evt.wb   = sb.wb_valid   && (sb.wb_rd    == REG_IDX_W'(i));
    assign evt.kill = sb.kill_valid && (sb.kill_rd  == REG_IDX_W'(i));
    assign delta    = net_delta(evt);

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .delta_i (delta),
      .cnt_d_o (cnt_d[i]),
      .nz_o    (nz_v[i]),
      .full_o  (full_v[i]),
      .uf_o    (uf_v[i])
    );
  end

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < NREGS; i++)
      inflight_d = inflight_d + INFLIGHT_W'(cnt_d[i]);
  end

  assign err_d = err_q || (|uf_v);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sb.stall    = stall;
  assign sb.rs1_busy = rs1_busy;
  assign sb.rs2_busy = rs2_busy;
  assign sb.inflight = inflight_q;
  assign sb.err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW, saturation, simultaneous
// events, kill/underflow and x0 handling.
module tb_reg_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_we    = 1'b0;
    sb_if.issue_rd    = 5'd0;
    sb_if.rs1         = 5'd0;
    sb_if.rs2         = 5'd0;
    sb_if.rs1_used    = 1'b0;
    sb_if.rs2_used    = 1'b0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_rd       = 5'd0;
    sb_if.kill_valid  = 1'b0;
    sb_if.kill_rd     = 5'd0;
  endtask

  // inputs change 2 time units after the rising edge; checks land 1 later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer_write(input logic [4:0] rd);
    clear();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_we    = 1'b1;
    sb_if.issue_rd    = rd;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear();
    rst = 1'b0;
    sb_if.issue_valid = 1'b1;
    sb_if.rs1 = 5'd5; sb_if.rs1_used = 1'b1;
    #3;
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", sb_if.stall); end
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", sb_if.err); end
    tick();
    rst = 1'b1;
    tick();
    // build cnt[5]=2 and a sticky err, then reset asynchronously mid-cycle
    offer_write(5'd5); tick();
    offer_write(5'd5); tick();
    clear(); sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd1; tick();
    clear(); sb_if.rs1 = 5'd5; sb_if.rs1_used = 1'b1; #1;
    checks++; if (sb_if.inflight !== 6'd2) begin errors++; $display("FAIL pre_reset_inflight got %0d want 2", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got %b want 1", sb_if.err); end
    checks++; if (sb_if.rs1_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", sb_if.rs1_busy); end
    rst = 1'b0;
    #1;
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL async_reset_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL async_reset_err got %b want 0", sb_if.err); end
    checks++; if (sb_if.rs1_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", sb_if.rs1_busy); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    offer_write(5'd5); #1;
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue_stall got %b want 0", sb_if.stall); end
    tick();
    clear();
    sb_if.issue_valid = 1'b1;
    sb_if.rs1 = 5'd5; sb_if.rs1_used = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc %0d got %b want 1", c, sb_if.stall); end
      checks++; if (sb_if.rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy cyc %0d got %b want 1", c, sb_if.rs1_busy); end
      tick();
    end
    sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd5; #1;
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL raw_wb_cycle_stall got %b want 1", sb_if.stall); end
    tick();
    sb_if.wb_valid = 1'b0; #1;
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL raw_after_wb_stall got %b want 0", sb_if.stall); end
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL raw_inflight got %0d want 0", sb_if.inflight); end
    tick();
    clear();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 3; n++) begin
      offer_write(5'd7); #1;
      checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL sat_issue%0d_stall got %b want 0", n, sb_if.stall); end
      tick();
    end
    offer_write(5'd7); #1;
    checks++; if (sb_if.inflight !== 6'd3) begin errors++; $display("FAIL sat_inflight got %0d want 3", sb_if.inflight); end
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL sat_fourth_stall got %b want 1", sb_if.stall); end
    tick();
    clear(); #1;
    checks++; if (sb_if.inflight !== 6'd3) begin errors++; $display("FAIL sat_no_wrap_inflight got %0d want 3", sb_if.inflight); end
    for (int n = 0; n < 3; n++) begin
      clear(); sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd7; tick();
    end
    clear(); #1;
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL sat_drain_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL sat_drain_err got %b want 0", sb_if.err); end
  endtask

  task automatic test_simultaneous();
    offer_write(5'd9); tick();
    offer_write(5'd9);
    sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd9; #1;
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL sim_stall got %b want 0", sb_if.stall); end
    tick();
    clear(); sb_if.rs2 = 5'd9; sb_if.rs2_used = 1'b1; #1;
    checks++; if (sb_if.inflight !== 6'd1) begin errors++; $display("FAIL sim_inflight got %0d want 1", sb_if.inflight); end
    checks++; if (sb_if.rs2_busy !== 1'b1) begin errors++; $display("FAIL sim_rs2_busy got %b want 1", sb_if.rs2_busy); end
    clear(); sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd9; tick();
    // wb + kill to the same register is a -2 step
    offer_write(5'd11); tick();
    offer_write(5'd11); tick();
    clear(); #1;
    checks++; if (sb_if.inflight !== 6'd2) begin errors++; $display("FAIL wbkill_pre_inflight got %0d want 2", sb_if.inflight); end
    sb_if.wb_valid = 1'b1;   sb_if.wb_rd = 5'd11;
    sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd11;
    tick();
    clear(); #1;
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL wbkill_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL wbkill_err got %b want 0", sb_if.err); end
  endtask

  task automatic test_kill();
    offer_write(5'd3); tick();
    clear(); sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd3; tick();
    clear(); sb_if.rs1 = 5'd3; sb_if.rs1_used = 1'b1; #1;
    checks++; if (sb_if.rs1_busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", sb_if.rs1_busy); end
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL kill_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL kill_err got %b want 0", sb_if.err); end
    clear(); sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd3; tick();
    clear(); sb_if.rs1 = 5'd3; sb_if.rs1_used = 1'b1; #1;
    checks++; if (sb_if.err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b want 1", sb_if.err); end
    checks++; if (sb_if.inflight !== 6'd0) begin errors++; $display("FAIL underflow_inflight got %0d want 0", sb_if.inflight); end
    checks++; if (sb_if.rs1_busy !== 1'b0) begin errors++; $display("FAIL underflow_busy got %b want 0", sb_if.rs1_busy); end
    // clamped at 0: one new issue must read back as exactly 1 pending
    offer_write(5'd3); tick();
    clear(); tick(); #1;
    checks++; if (sb_if.inflight !== 6'd1) begin errors++; $display("FAIL clamp_inflight got %0d want 1", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_if.err); end
    do_reset();
  endtask

  task automatic test_x0();
    offer_write(5'd4); tick();
    offer_write(5'd0);
    sb_if.rs1 = 5'd0; sb_if.rs1_used = 1'b1; #1;
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", sb_if.stall); end
    checks++; if (sb_if.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b want 0", sb_if.rs1_busy); end
    tick();
    clear(); sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd0; tick();
    clear(); #1;
    checks++; if (sb_if.inflight !== 6'd1) begin errors++; $display("FAIL x0_inflight got %0d want 1", sb_if.inflight); end
    checks++; if (sb_if.err !== 1'b0) begin errors++; $display("FAIL x0_wb_err got %b want 0", sb_if.err); end
    sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd4; tick();
    clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear();
    rst = 1'b0;
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_kill();
    test_x0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
